// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: host-side run controller ahead of the CPU status block.
// Turns monitor run/quit/step strobes and PC breakpoint matches into
// single-cycle cpu_start / quit_cmd pulses, counts retired instructions
// and records why the CPU stopped.
module cpu_run_ctrl #(
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_run,
  input  logic              cmd_quit,
  input  logic              cmd_step,
  input  logic [STEP_W-1:0] step_num,
  input  logic              brk_en,
  input  logic [29:0]       brk_pc,
  input  logic              ret_valid,
  input  logic [29:0]       ret_pc,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic              run_busy,
  output logic [1:0]        halt_reason,
  output logic [STEP_W-1:0] step_remain,
  output logic [CNT_W-1:0]  ret_cnt
);

  typedef enum logic [2:0] {
    IDLE, START_P, RUN, STEP_P, STEP, QUIT_P
  } state_t;

  localparam logic [1:0] HR_QUIT = 2'd1;
  localparam logic [1:0] HR_BRK  = 2'd2;
  localparam logic [1:0] HR_STEP = 2'd3;

  state_t state;
  logic   brk_hit;
  logic   step_last;

  assign brk_hit   = brk_en & ret_valid & (ret_pc == brk_pc);
  assign step_last = (state == STEP) & ret_valid & (step_remain == STEP_W'(1));

  // Run/step FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cpu_start   <= 1'b0;
      quit_cmd    <= 1'b0;
      run_busy    <= 1'b0;
      halt_reason <= 2'd0;
      step_remain <= '0;
      ret_cnt     <= '0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      cpu_start <= 1'b0;
      quit_cmd  <= 1'b0;
      case (state)
        IDLE: begin
          // cmd_run takes precedence over a simultaneous cmd_step.
          if (cmd_run) begin
            state       <= START_P;
            cpu_start   <= 1'b1;
            run_busy    <= 1'b1;
            halt_reason <= 2'd0;
            ret_cnt     <= '0;
          end else if (cmd_step && step_num != '0) begin
            state       <= STEP_P;
            cpu_start   <= 1'b1;
            run_busy    <= 1'b1;
            halt_reason <= 2'd0;
            ret_cnt     <= '0;
            step_remain <= step_num;
          end
        end
        START_P: state <= RUN;
        STEP_P:  state <= STEP;
        RUN, STEP: begin
          // The retirement in a halting cycle is still counted.
          if (ret_valid) begin
            ret_cnt <= ret_cnt + CNT_W'(1);
            if (state == STEP) step_remain <= step_remain - STEP_W'(1);
          end
          if (cmd_quit) begin
            state       <= QUIT_P;
            quit_cmd    <= 1'b1;
            halt_reason <= HR_QUIT;
          end else if (brk_hit) begin
            state       <= QUIT_P;
            quit_cmd    <= 1'b1;
            halt_reason <= HR_BRK;
          end else if (step_last) begin
            state       <= QUIT_P;
            quit_cmd    <= 1'b1;
            halt_reason <= HR_STEP;
          end
        end
        QUIT_P: begin
          state    <= IDLE;
          run_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          run_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus pushes the expected pulse
// (kind, cycle, halt_reason, ret_cnt, step_remain) and a monitor pops and
// compares whenever cpu_start or quit_cmd is seen.
module tb_cpu_run_ctrl;

  localparam int STEP_W = 16;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_run = 1'b0, cmd_quit = 1'b0, cmd_step = 1'b0;
  logic [STEP_W-1:0] step_num = '0;
  logic              brk_en = 1'b0;
  logic [29:0]       brk_pc = '0;
  logic              ret_valid = 1'b0;
  logic [29:0]       ret_pc = '0;
  logic              cpu_start, quit_cmd, run_busy;
  logic [1:0]        halt_reason;
  logic [STEP_W-1:0] step_remain;
  logic [CNT_W-1:0]  ret_cnt;

  cpu_run_ctrl #(.STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_quit(cmd_quit),
    .cmd_step(cmd_step), .step_num(step_num), .brk_en(brk_en),
    .brk_pc(brk_pc), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .cpu_start(cpu_start), .quit_cmd(quit_cmd), .run_busy(run_busy),
    .halt_reason(halt_reason), .step_remain(step_remain), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_quit;
    int          at;
    logic [1:0]  hr;
    logic [31:0] cnt;
    logic [15:0] rem;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit q, input int at, input logic [1:0] hr,
                      input logic [31:0] cnt, input logic [15:0] rem);
    ev_t e;
    e.is_quit = q; e.at = at; e.hr = hr; e.cnt = cnt; e.rem = rem;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && (cpu_start || quit_cmd)) begin
      if (cpu_start && quit_cmd) chk("pulse_overlap", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {cpu_start, quit_cmd}, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk(e.is_quit ? "quit_kind" : "start_kind", quit_cmd, e.is_quit);
        chk("pulse_cycle", cyc, e.at);
        chk("halt_reason", halt_reason, e.hr);
        chk("ret_cnt", ret_cnt, e.cnt);
        chk("step_remain", step_remain, e.rem);
        chk("run_busy", run_busy, 1);
      end
    end
  end

  // Advance to just after the next edge and clear the strobes.
  task automatic next();
    @(posedge clk); #1;
    cmd_run = 0; cmd_quit = 0; cmd_step = 0; ret_valid = 0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) next();
  endtask

  initial begin
    // Reset state
    wait_n(3);
    chk("rst_start", cpu_start, 0); chk("rst_quit", quit_cmd, 0);
    chk("rst_busy", run_busy, 0);   chk("rst_hr", halt_reason, 0);
    chk("rst_rem", step_remain, 0); chk("rst_cnt", ret_cnt, 0);
    rst = 0;
    wait_n(2);

    // Free run, 10 retirements, host quit (ret_valid in QUIT_P ignored)
    cmd_run = 1; push(0, cyc + 1, 0, 0, 0);
    next(); chk("busy_after_start", run_busy, 1);
    for (int i = 0; i < 10; i++) begin next(); ret_valid = 1; ret_pc = 30'(i); end
    wait_n(2); chk("cnt_10", ret_cnt, 10);
    cmd_quit = 1; push(1, cyc + 1, 1, 10, 0);
    next(); ret_valid = 1;
    next(); chk("busy_clear", run_busy, 0); chk("cnt_hold", ret_cnt, 10);
    wait_n(2); chk("hr_hold", halt_reason, 1);

    // Step 3 with stalls; retirement during STEP_P ignored
    cmd_step = 1; step_num = 3; push(0, cyc + 1, 0, 0, 3);
    next(); ret_valid = 1;
    next(); ret_valid = 1;
    wait_n(2); ret_valid = 1;
    wait_n(3); ret_valid = 1; push(1, cyc + 1, 3, 3, 0);
    wait_n(3);
    chk("step_hr", halt_reason, 3); chk("step_rem", step_remain, 0);
    chk("step_cnt", ret_cnt, 3);

    // Breakpoint at 0x40
    brk_en = 1; brk_pc = 30'h40;
    cmd_run = 1; push(0, cyc + 1, 0, 0, 0);
    wait_n(2); ret_valid = 1; ret_pc = 30'h3F;
    next(); ret_valid = 1; ret_pc = 30'h40; push(1, cyc + 1, 2, 2, 0);
    wait_n(3);

    // Same with breakpoint disabled: no halt until host quit
    brk_en = 0;
    cmd_run = 1; push(0, cyc + 1, 0, 0, 0);
    wait_n(2); ret_valid = 1; ret_pc = 30'h3F;
    next(); ret_valid = 1; ret_pc = 30'h40;
    wait_n(4); cmd_quit = 1; push(1, cyc + 1, 1, 2, 0);
    wait_n(3);

    // Final step cycle collides with quit and breakpoint: quit wins
    cmd_step = 1; step_num = 2; push(0, cyc + 1, 0, 0, 2);
    wait_n(2); ret_valid = 1; ret_pc = 30'h0;
    next(); brk_en = 1; brk_pc = 30'h5; ret_valid = 1; ret_pc = 30'h5;
    cmd_quit = 1; push(1, cyc + 1, 1, 2, 0);
    wait_n(3); brk_en = 0;
    chk("coll_rem", step_remain, 0); chk("coll_hr", halt_reason, 1);

    // step_num=0 and quit in IDLE are ignored
    cmd_step = 1; step_num = 0;
    next(); cmd_quit = 1;
    wait_n(3); chk("step0_idle", run_busy, 0);

    // run and step together: run wins, step_remain untouched
    cmd_run = 1; cmd_step = 1; step_num = 7; push(0, cyc + 1, 1, 2, 0);
    // halt_reason/ret_cnt cleared at the start edge, so expectation is 0/0
    exp_q[exp_q.size()-1].hr = 0; exp_q[exp_q.size()-1].cnt = 0;
    wait_n(2); ret_valid = 1;
    next(); cmd_quit = 1; push(1, cyc + 1, 1, 1, 0);
    wait_n(3);

    // Reset mid-STEP with a quit in flight: no quit_cmd afterwards
    cmd_step = 1; step_num = 5; push(0, cyc + 1, 0, 0, 5);
    wait_n(2); ret_valid = 1;
    next(); cmd_quit = 1;
    #2 rst = 1; cmd_quit = 0;
    #1;
    chk("arst_busy", run_busy, 0); chk("arst_cnt", ret_cnt, 0);
    chk("arst_rem", step_remain, 0); chk("arst_start", cpu_start, 0);
    chk("arst_quit", quit_cmd, 0); chk("arst_hr", halt_reason, 0);
    wait_n(2); rst = 0;
    wait_n(6);
    chk("post_rst_busy", run_busy, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
